// File: rtl/matmul_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// matmul_pkg : shared sizes and serializer state encoding.   Rev 1.0
// ---------------------------------------------------------------------------
package matmul_pkg;

  localparam int ELEM_W_DEF = 16;
  localparam int MAX_N_DEF  = 3;
  localparam int CNT_W      = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_FREE = 3'd3,
    NEXT      = 3'd4,
    FINISH    = 3'd5
  } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/result_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// result_serializer : streams a captured NxN result matrix to a UART, MSB first. Rev 1.0
// ---------------------------------------------------------------------------
module result_serializer
  import matmul_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int MAX_N  = MAX_N_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic [ELEM_W*MAX_N*MAX_N-1:0]   result,
  input  logic [3:0]                      matrix_size,
  input  logic                            tx_busy,
  output logic [7:0]                      tx_data,
  output logic                            tx_start,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int RES_W = ELEM_W * MAX_N * MAX_N;

  ser_state_t             state_q, state_d;
  logic [RES_W-1:0]       data_q, data_d;
  logic [CNT_W-1:0]       n_q, n_d;
  logic [CNT_W-1:0]       row_q, row_d;
  logic [CNT_W-1:0]       col_q, col_d;
  logic                   byte_q, byte_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [ELEM_W-1:0]      cur_elem;
  logic [7:0]             cur_byte;
  logic [CNT_W-1:0]       n_last;
  logic                   size_ok;

  assign size_ok  = (matrix_size != 4'd0) && (matrix_size <= CNT_W'(MAX_N));
  assign n_last   = n_q - CNT_W'(1);
  assign cur_byte = byte_q ? cur_elem[7:0] : cur_elem[ELEM_W-1 -: 8];

  always_comb begin
    cur_elem = '0;
    for (int r = 0; r < MAX_N; r++) begin
      for (int c = 0; c < MAX_N; c++) begin
        if (row_q == CNT_W'(r) && col_q == CNT_W'(c)) begin
          cur_elem = data_q[(r*MAX_N+c)*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    n_d        = n_q;
    row_d      = row_q;
    col_d      = col_q;
    byte_d     = byte_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (load) begin
          if (size_ok) begin
            data_d  = result;
            n_d     = matrix_size;
            row_d   = '0;
            col_d   = '0;
            byte_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = START;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // A transmitter that is still busy from elsewhere holds the strobe back.
      START: begin
        if (!tx_busy) begin
          tx_data_d  = cur_byte;
          tx_start_d = 1'b1;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (tx_busy) state_d = WAIT_FREE;
      end
      WAIT_FREE: begin
        if (!tx_busy) state_d = NEXT;
      end
      NEXT: begin
        state_d = START;
        if (!byte_q) begin
          byte_d = 1'b1;
        end else begin
          byte_d = 1'b0;
          if (col_q == n_last) begin
            col_d = '0;
            if (row_q == n_last) begin
              state_d = FINISH;
            end else begin
              row_d = row_q + CNT_W'(1);
            end
          end else begin
            col_d = col_q + CNT_W'(1);
          end
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      n_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      byte_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      n_q        <= n_d;
      row_q      <= row_d;
      col_q      <= col_d;
      byte_q     <= byte_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
`default_nettype wire

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 SHALL have parameter ELEM_W, default 16, result element width in bits.
REQ-002 SHALL have parameter MAX_N, default 3, matrix dimension of the result bus layout.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port load  input  1  one-cycle request to capture a result and start sending.
REQ-006 SHALL have port result  input  ELEM_W*MAX_N*MAX_N (144)  product matrix; element (r,c) occupies result[(r*MAX_N+c)*ELEM_W +: ELEM_W].
REQ-007 SHALL have port matrix_size  input  4  active dimension N, valid range 1..MAX_N.
REQ-008 SHALL have port tx_busy  input  1  UART transmitter busy flag.
REQ-009 SHALL have port tx_data  output  8  byte presented to the UART transmitter.
REQ-010 SHALL have port tx_start  output  1  one-cycle UART transmit strobe.
REQ-011 SHALL have port busy  output  1  high from load acceptance until done.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the last byte completes.
REQ-013 SHALL have port err  output  1  one-cycle pulse when load is rejected for an invalid size.

Function
REQ-014 SHALL implement states IDLE, START, WAIT_ACK, WAIT_FREE, NEXT, FINISH.
REQ-015 SHALL, in IDLE with load=1 and 1<=matrix_size<=MAX_N, capture result and matrix_size into internal registers, clear row, column and byte counters, and go to START.
REQ-016 SHALL, in IDLE with load=1 and matrix_size of 0 or >MAX_N, pulse err for one cycle the next cycle, send nothing, and stay in IDLE.
REQ-017 SHALL ignore load while busy=1; captured data is unaffected.
REQ-018 SHALL send elements row-major (r outer, c inner, both 0..N-1), each element high byte first then low byte, for exactly 2*N*N bytes.
REQ-019 SHALL, in START, drive tx_data with the current byte and assert tx_start for exactly one cycle, then go to WAIT_ACK.
REQ-020 SHALL, in WAIT_ACK, wait until tx_busy=1, then go to WAIT_FREE.
REQ-021 SHALL, in WAIT_FREE, wait until tx_busy=0, then go to NEXT.
REQ-022 SHALL keep tx_data stable from START until WAIT_FREE exits.
REQ-023 SHALL, in NEXT, advance byte→column→row; column wraps at N-1 into row+1; after the last byte go to FINISH, else go to START.
REQ-024 SHALL, in FINISH, pulse done for one cycle, deassert busy the same cycle, and return to IDLE.
REQ-025 SHALL assert tx_start the second clock after the accepting load edge (load sampled at edge t, tx_start high during cycle t+1).
REQ-026 SHALL treat elements as unsigned bit fields; no arithmetic on data.
REQ-027 SHALL never assert tx_start while tx_busy=1 at the START entry; a START entered with tx_busy=1 holds in START with tx_start low until tx_busy=0.

Reset
REQ-028 SHALL, when rst=0 at a clock edge, force state IDLE, counters 0, tx_data=8'h00, tx_start=0, busy=0, done=0, err=0.
REQ-029 SHALL abort any transfer in progress on reset mid-operation without a done pulse; the partially sent frame is not resumed.

Structure
REQ-030 SHALL take ELEM_W, MAX_N defaults and the state encoding from the shared matmul package.
REQ-031 SHALL be a single module with no sub-modules.

Verification
REQ-032 N=2, result elements (0,0)=16'h1234,(0,1)=16'h0005,(1,0)=16'hABCD,(1,1)=16'hFFFF, UART model busy 10 cycles per byte -> bytes 12,34,00,05,AB,CD,FF,FF then one done pulse.
REQ-033 N=3, element k=16'h0100+k -> 18 bytes 01,00,01,01,...,01,08 in row-major order; element (0,2) sent before (1,0).
REQ-034 load with matrix_size=0 and with matrix_size=4 -> err pulse each, no tx_start, busy stays 0.
REQ-035 N=1 transfer, second load pulse during WAIT_FREE with different result -> only the first captured element sent, 2 bytes total.
REQ-036 rst=0 asserted during byte 3 of an N=2 transfer -> all outputs reset next edge, no done; a following load sends a full 8-byte frame.
REQ-037 tx_busy held high at load time for 20 cycles -> tx_start withheld until tx_busy=0, then a single one-cycle strobe.
